// File: rtl/round_timer_ctrl.sv
// Round sequencer for the whack-a-mole game: steers the external seconds counter
// through the READY countdown, the timed PLAY window, PAUSE and DONE on the 1 Hz clock.
module round_timer_ctrl #(
  parameter int ROUND_SECS = 30,
  parameter int READY_SECS = 3
) (
  input  logic       clk_1hz,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_pause_req,
  input  logic       i_abort,
  input  logic [5:0] i_sec,
  output logic       o_cnt_enable,
  output logic       o_cnt_clear,
  output logic [1:0] o_ready_cnt,
  output logic [5:0] o_time_left,
  output logic       o_play_active,
  output logic       o_round_done,
  output logic [7:0] o_round_count,
  output logic [2:0] o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [5:0] ROUND_LEN  = 6'(ROUND_SECS);
  localparam logic [5:0] LAST_SEC   = 6'(ROUND_SECS - 1);
  localparam logic [1:0] READY_LEN  = 2'(READY_SECS);
  localparam logic       SKIP_READY = (READY_SECS == 0);

  state_t     r_state, w_state_next;
  logic [1:0] r_ready_cnt, w_ready_cnt_next;
  logic [7:0] r_round_count, w_round_count_next;
  logic       r_start_d, r_pause_d;
  logic       w_start_rise, w_pause_rise, w_round_end;

  assign w_start_rise = i_start & ~r_start_d;
  assign w_pause_rise = i_pause_req & ~r_pause_d;
  // The counter steps to ROUND_SECS on the same edge that moves us into DONE.
  assign w_round_end  = (r_state == S_PLAY) && (i_sec == LAST_SEC);

  always_ff @(posedge clk_1hz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ready_cnt   <= 2'd0;
      r_round_count <= 8'd0;
      r_start_d     <= 1'b0;
      r_pause_d     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_ready_cnt   <= w_ready_cnt_next;
      r_round_count <= w_round_count_next;
      r_start_d     <= i_start;
      r_pause_d     <= i_pause_req;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_ready_cnt_next   = r_ready_cnt;
    w_round_count_next = r_round_count;
    o_cnt_enable       = 1'b0;
    o_cnt_clear        = 1'b0;
    o_time_left        = ROUND_LEN;

    if (i_abort) begin
      w_state_next     = S_IDLE;
      w_ready_cnt_next = 2'd0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_rise) begin
            if (SKIP_READY) begin
              w_state_next     = S_PLAY;
              w_ready_cnt_next = 2'd0;
            end else begin
              w_state_next     = S_READY;
              w_ready_cnt_next = READY_LEN;
            end
          end
        end
        S_READY: begin
          if (r_ready_cnt <= 2'd1) begin
            w_state_next     = S_PLAY;
            w_ready_cnt_next = 2'd0;
          end else begin
            w_ready_cnt_next = r_ready_cnt - 2'd1;
          end
        end
        S_PLAY: begin
          if (w_round_end) begin
            w_state_next = S_DONE;
            if (r_round_count != 8'hFF) begin
              w_round_count_next = r_round_count + 8'd1;
            end
          end else if (w_pause_rise) begin
            w_state_next = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (w_pause_rise) begin
            w_state_next = S_PLAY;
          end
        end
        default: begin
          w_state_next     = S_IDLE;
          w_ready_cnt_next = 2'd0;
        end
      endcase
    end

    // Moore decode: the counter sees these on the same edge the FSM moves.
    case (r_state)
      S_IDLE, S_READY: begin
        o_cnt_clear = 1'b1;
        o_time_left = ROUND_LEN;
      end
      S_PLAY, S_PAUSE: begin
        o_cnt_enable = (r_state == S_PLAY);
        o_time_left  = (i_sec >= ROUND_LEN) ? 6'd0 : (ROUND_LEN - i_sec);
      end
      S_DONE: begin
        o_time_left = 6'd0;
      end
      default: begin
        o_cnt_clear = 1'b1;
      end
    endcase
  end

  assign o_ready_cnt   = r_ready_cnt;
  assign o_round_count = r_round_count;
  assign o_play_active = (r_state == S_PLAY);
  assign o_round_done  = (r_state == S_DONE);
  assign o_state       = r_state;

endmodule

// File: tb/tb_round_timer_ctrl.sv
// Directed bench for round_timer_ctrl: a behavioural seconds counter closes the loop,
// a vector table walks three rounds, then reset-mid-round and tally saturation are checked.
module tb_round_timer_ctrl;

  localparam logic [2:0] IDLE = 3'd0, READY = 3'd1, PLAY = 3'd2, PAUSE = 3'd3, DONE = 3'd4;

  typedef struct {
    logic       start;
    logic       pause;
    logic       abort;
    logic [2:0] exp_state;
    logic [5:0] exp_sec;
    logic [1:0] exp_ready;
    logic [7:0] exp_count;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  logic       clk_1hz = 1'b0;
  logic       rst_n   = 1'b1;
  logic       start = 1'b0, pause_req = 1'b0, abort = 1'b0;
  logic [5:0] sec = '0;
  logic       cnt_enable, cnt_clear, play_active, round_done;
  logic [1:0] ready_cnt;
  logic [5:0] time_left;
  logic [7:0] round_count;
  logic [2:0] state;

  // Second instance at the parameter limits: 1 s round, no READY phase.
  logic       f_start = 1'b0, f_abort = 1'b0;
  logic [5:0] f_sec = '0;
  logic       f_cnt_enable, f_cnt_clear, f_play_active, f_round_done;
  logic [1:0] f_ready_cnt;
  logic [5:0] f_time_left;
  logic [7:0] f_round_count;
  logic [2:0] f_state;

  always #5 clk_1hz = ~clk_1hz;

  round_timer_ctrl #(.ROUND_SECS(30), .READY_SECS(3)) dut (
    .clk_1hz(clk_1hz), .rst_n(rst_n), .i_start(start), .i_pause_req(pause_req),
    .i_abort(abort), .i_sec(sec), .o_cnt_enable(cnt_enable), .o_cnt_clear(cnt_clear),
    .o_ready_cnt(ready_cnt), .o_time_left(time_left), .o_play_active(play_active),
    .o_round_done(round_done), .o_round_count(round_count), .o_state(state)
  );

  round_timer_ctrl #(.ROUND_SECS(1), .READY_SECS(0)) dut_fast (
    .clk_1hz(clk_1hz), .rst_n(rst_n), .i_start(f_start), .i_pause_req(1'b0),
    .i_abort(f_abort), .i_sec(f_sec), .o_cnt_enable(f_cnt_enable), .o_cnt_clear(f_cnt_clear),
    .o_ready_cnt(f_ready_cnt), .o_time_left(f_time_left), .o_play_active(f_play_active),
    .o_round_done(f_round_done), .o_round_count(f_round_count), .o_state(f_state)
  );

  // Behavioural sec_counter: clear wins over enable.
  always_ff @(posedge clk_1hz) begin
    if (cnt_clear) sec <= 6'd0;
    else if (cnt_enable) sec <= sec + 6'd1;
    if (f_cnt_clear) f_sec <= 6'd0;
    else if (f_cnt_enable) f_sec <= f_sec + 6'd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [5:0] exp_tl(input logic [2:0] st, input logic [5:0] s);
    case (st)
      IDLE, READY: return 6'd30;
      DONE:        return 6'd0;
      default:     return (s >= 6'd30) ? 6'd0 : 6'd30 - s;
    endcase
  endfunction

  task automatic add(input logic s, input logic p, input logic a, input logic [2:0] st,
                     input logic [5:0] sc, input logic [1:0] rdy, input logic [7:0] cnt);
    vec_t v;
    v.start = s; v.pause = p; v.abort = a;
    v.exp_state = st; v.exp_sec = sc; v.exp_ready = rdy; v.exp_count = cnt;
    vecs.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk_1hz);
    #1;
  endtask

  initial begin
    // Round 1: READY countdown, full 30 s PLAY with start held high, DONE holds.
    add(0,0,0, IDLE, 0,0,0);
    add(1,0,0, READY,0,3,0);
    add(1,1,0, READY,0,2,0);           // pause rise ignored in READY
    add(1,0,0, READY,0,1,0);
    add(1,0,0, PLAY, 0,0,0);
    for (int k = 1; k <= 29; k++) add(1,0,0, PLAY, 6'(k),0,0);
    add(1,0,0, DONE,30,0,1);
    for (int k = 0; k < 3; k++) add(1,0,0, DONE,30,0,1);
    add(0,0,0, DONE,30,0,1);
    // Round 2: restart from DONE, pause/resume, start ignored in PAUSE, abort in PLAY.
    add(1,0,0, READY,30,3,1);
    add(1,0,0, READY,0,2,1);
    add(1,0,0, READY,0,1,1);
    add(1,0,0, PLAY, 0,0,1);
    for (int k = 1; k <= 9; k++) add(0,0,0, PLAY, 6'(k),0,1);
    add(0,1,0, PAUSE,10,0,1);
    for (int k = 0; k < 4; k++) add(0,1,0, PAUSE,10,0,1);
    add(0,0,0, PAUSE,10,0,1);
    add(1,0,0, PAUSE,10,0,1);
    add(0,1,0, PLAY, 10,0,1);
    add(0,0,0, PLAY, 11,0,1);
    add(0,0,0, PLAY, 12,0,1);
    add(0,0,1, IDLE, 13,0,1);
    add(0,0,0, IDLE, 0,0,1);
    // Round 3: pause rise on the final second loses to end-of-round.
    add(1,0,0, READY,0,3,1);
    add(0,0,0, READY,0,2,1);
    add(0,0,0, READY,0,1,1);
    add(0,0,0, PLAY, 0,0,1);
    for (int k = 1; k <= 29; k++) add(0,0,0, PLAY, 6'(k),0,1);
    add(0,1,0, DONE,30,0,2);
    add(0,0,0, DONE,30,0,2);
    add(0,1,0, DONE,30,0,2);
    add(0,0,1, IDLE,30,0,2);
    add(0,0,0, IDLE, 0,0,2);

    #1 rst_n = 1'b0;
    #1;
    chk("reset state", state, IDLE);
    chk("reset cnt_clear", cnt_clear, 1);
    chk("reset cnt_enable", cnt_enable, 0);
    chk("reset time_left", time_left, 30);
    chk("reset round_count", round_count, 0);
    chk("reset ready_cnt", ready_cnt, 0);
    tick(); tick();
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      start = vecs[i].start; pause_req = vecs[i].pause; abort = vecs[i].abort;
      tick();
      chk($sformatf("v%0d state", i), state, vecs[i].exp_state);
      chk($sformatf("v%0d sec", i), sec, vecs[i].exp_sec);
      chk($sformatf("v%0d time_left", i), time_left, exp_tl(vecs[i].exp_state, vecs[i].exp_sec));
      chk($sformatf("v%0d ready_cnt", i), ready_cnt, vecs[i].exp_ready);
      chk($sformatf("v%0d round_count", i), round_count, vecs[i].exp_count);
      chk($sformatf("v%0d cnt_enable", i), cnt_enable, vecs[i].exp_state == PLAY);
      chk($sformatf("v%0d cnt_clear", i), cnt_clear,
          (vecs[i].exp_state == IDLE) || (vecs[i].exp_state == READY));
      chk($sformatf("v%0d play_active", i), play_active, vecs[i].exp_state == PLAY);
      chk($sformatf("v%0d round_done", i), round_done, vecs[i].exp_state == DONE);
    end

    // Asynchronous reset in the middle of PLAY.
    start = 1'b1; abort = 1'b0; pause_req = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    chk("pre-reset state", state, PLAY);
    for (int k = 0; k < 5; k++) tick();
    chk("pre-reset sec", sec, 5);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset state", state, IDLE);
    chk("async reset round_count", round_count, 0);
    chk("async reset cnt_clear", cnt_clear, 1);
    chk("async reset time_left", time_left, 30);
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post-reset state", state, IDLE);
    chk("post-reset sec", sec, 0);

    // Limit-parameter instance: skip READY, 1 s rounds, tally saturates at 255.
    for (int r = 1; r <= 256; r++) begin
      f_start = 1'b1; f_abort = 1'b0;
      tick();
      if (r == 1) begin
        chk("fast PLAY state", f_state, PLAY);
        chk("fast PLAY sec", f_sec, 0);
        chk("fast PLAY time_left", f_time_left, 1);
      end
      tick();
      if (r == 1 || r >= 254) begin
        chk($sformatf("fast r%0d state", r), f_state, DONE);
        chk($sformatf("fast r%0d round_count", r), f_round_count, (r > 255) ? 255 : r);
        chk($sformatf("fast r%0d time_left", r), f_time_left, 0);
      end
      f_start = 1'b0; f_abort = 1'b1;
      tick();
      f_abort = 1'b0;
      tick();
      if (r == 256) begin
        chk("fast abort keeps tally", f_round_count, 255);
        chk("fast idle sec", f_sec, 0);
      end
    end
    chk("main idle during fast run", state, IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
